// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and sizing helper for the serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit operation still needs a one-bit counter.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addsub_param_digit.sv
// serial_digit_add: combinational DIGIT-wide ripple-carry slice, also exposing the carry into its MSB.
module serial_digit_add #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        s      = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = x[i] ^ y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_param.sv
// serial_addsub_param: digit-serial two's-complement add/subtract with carry/overflow flags
// and valid/ready handshakes; one DIGIT-wide slice is reused for NDIG cycles.
module serial_addsub_param
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_w(NDIG);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_addsub_param: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum, w_sum_n;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout, r_ovf;
    logic [DIGIT-1:0] w_ds;
    logic             w_co, w_cmsb, w_last, w_acc;

    serial_digit_add #(.DIGIT(DIGIT)) u_slice (
        .x    (r_a[DIGIT-1:0]),
        .y    (r_b[DIGIT-1:0]),
        .cin  (r_carry),
        .s    (w_ds),
        .co   (w_co),
        .c_msb(w_cmsb)
    );

    // Result digits enter at the top and migrate down, so after NDIG steps they sit in place.
    if (DIGIT == WIDTH) begin : g_full
        assign w_sum_n = w_ds;
    end else begin : g_part
        assign w_sum_n = {w_ds, r_sum[WIDTH-1:DIGIT]};
    end

    assign w_last = r_cnt == CW'(NDIG - 1);
    assign w_acc  = r_state == IDLE && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = w_acc                          ? RUN  :
                 (r_state == RUN  && w_last)    ? DONE :
                 (r_state == DONE && out_ready) ? IDLE : r_state;
    end

    // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_acc) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= sub;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_n;
            r_cnt   <= r_cnt + 1'b1;
            r_carry <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_cmsb ^ w_co;
            end
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
